// File: rtl/en_stream_pkg.sv
// Shared definitions for the enable-qualified sample stream blocks.
// Holds the default word width, the counter-width helper and drop counter width.
package en_stream_pkg;

   localparam int DATA_WIDH_DEF = 20;
   localparam int DROP_CNT_W    = 16;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/en_stream_ptr.sv
// Wrapping FIFO pointer with increment and synchronous clear.
// Wraps naturally from 2**W-1 back to 0.
module en_stream_ptr #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] ptr
);

   // pointer register; clear wins over increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= '0;
      else if (clr)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + 1'b1;
   end

endmodule

// File: rtl/en_stream_rx_fifo.sv
// Receiver FIFO for the en/data sample stream, re-issued on valid/ready.
// Optional drop counter enabled by defining ENRX_DROP_CNT_EN.
module en_stream_rx_fifo
   import en_stream_pkg::*;
#(
   parameter int DATA_WIDH = DATA_WIDH_DEF,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en_i,
   input  logic [DATA_WIDH-1:0]      data_i,
   input  logic                      clr_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [DATA_WIDH-1:0]      data_o,
   output logic [cnt_w(DEPTH)-1:0]   count_o,
   output logic                      afull_o,
   output logic                      full_o,
   output logic                      ovf_o
`ifdef ENRX_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0]     drop_cnt_o
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DATA_WIDH-1:0] mem [DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic                 push;
   logic                 pop;
   logic                 drop;
   logic                 wr_en;
   logic                 rd_en;

   // handshake decode; a flush suppresses every state change
   always_comb begin
      pop   = valid_o & ready_i;
      push  = en_i & (~full_o | pop);
      drop  = en_i & full_o & ~pop & ~clr_i;
      wr_en = push & ~clr_i;
      rd_en = pop & ~clr_i;
   end

   en_stream_ptr #(.W(AW)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wr_en),
      .clr   (clr_i),
      .ptr   (wr_ptr)
   );

   en_stream_ptr #(.W(AW)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd_en),
      .clr   (clr_i),
      .ptr   (rd_ptr)
   );

   // storage array, written only on an accepted push, never reset
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= data_i;
   end

   // occupancy tracks push minus pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_o <= '0;
      else if (clr_i)
         count_o <= '0;
      else
         count_o <= count_o + CW'(push) - CW'(pop);
   end

   // sticky loss flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_o <= 1'b0;
      else if (clr_i)
         ovf_o <= 1'b0;
      else if (drop)
         ovf_o <= 1'b1;
   end

`ifdef ENRX_DROP_CNT_EN
   // saturating count of discarded words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         drop_cnt_o <= '0;
      else if (clr_i)
         drop_cnt_o <= '0;
      else if (drop && drop_cnt_o != '1)
         drop_cnt_o <= drop_cnt_o + 1'b1;
   end
`endif

   // status flags and show-ahead head word, zeroed when empty
   always_comb begin
      valid_o = (count_o != '0);
      full_o  = (count_o == CW'(DEPTH));
      afull_o = (count_o >= CW'(AFULL_TH));
      data_o  = valid_o ? mem[rd_ptr] : '0;
   end

endmodule
